mem_stage_hs: RTL and testbench

- Next-generation memory stage for variable-latency data memory, replacing the fixed single-cycle dmem path.
- Sits between the EX/MEM and MEM/WB pipeline registers and drives a req/gnt/rvalid data-memory port.
- Stalls the pipeline through the hazard unit while a transaction is outstanding.
- Adds misalignment, bus-error and timeout faults, and supports XLEN 32 and 64.

---
 rtl/mem_stage_hs.sv | 244 ++++++++++++++++++++++++
 tb/tb_mem_stage_hs.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: memory pipeline stage for a variable-latency data memory.
//
// Sits between the EX/MEM and MEM/WB registers. Non-memory instructions and
// faulting accesses pass through in the same cycle. Aligned loads/stores are
// latched, issued on a req/gnt/rvalid port, and the pipeline is stalled until
// the response (or a timeout) has been registered and presented for one cycle.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   valid_in, MemRead, MemWrite, funct3, ALUResult, WriteData, RegWrite
//                         EX/MEM register contents
//   StallM                hold EX/MEM and earlier stages
//   valid_out, RegWriteOut, load_data, misaligned, bus_error
//                         MEM/WB capture strobe and result
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata
//                         request channel (held stable until mem_gnt)
//   mem_gnt, mem_rvalid, mem_rdata, mem_err
//                         grant and response channel
module mem_stage_hs #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            funct3,
    input  logic [XLEN-1:0]       ALUResult,
    input  logic [XLEN-1:0]       WriteData,
    input  logic                  RegWrite,
    output logic                  StallM,
    output logic                  valid_out,
    output logic                  RegWriteOut,
    output logic [XLEN-1:0]       load_data,
    output logic                  misaligned,
    output logic                  bus_error,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN/8-1:0]     mem_be,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    input  logic                  mem_err
);

    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OffW = $clog2(NB);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [NB-1:0]         be_q;
    logic [XLEN-1:0]       wdata_q;
    logic                  we_q;
    logic [2:0]            funct3_q;
    logic [OffW-1:0]       off_q;
    logic                  rw_q;
    logic [XLEN-1:0]       data_q;
    logic                  err_q;

    // Request decode
    logic [OffW-1:0] off;
    logic [3:0]      size_mask;  // access size in bytes, minus one
    logic            memop;
    logic            illegal;
    logic            fault;
    logic [NB-1:0]   be_base;
    logic [NB-1:0]   be;
    logic [XLEN-1:0] wdata_rep;

    assign off       = ALUResult[OffW-1:0];
    assign memop     = MemRead | MemWrite;
    assign size_mask = (4'd1 << funct3[1:0]) - 4'd1;

    always_comb begin
        illegal = (funct3 == 3'b111) || (MemWrite && funct3[2]);
        if (XLEN == 32) begin
            illegal = illegal || (funct3 == 3'b011) || (funct3 == 3'b110);
        end
    end

    assign fault = illegal | (|(off & size_mask[OffW-1:0]));

    always_comb begin
        unique case (funct3[1:0])
            2'd0:    be_base = NB'(4'h1);
            2'd1:    be_base = NB'(4'h3);
            2'd2:    be_base = NB'(4'hF);
            default: be_base = '1;
        endcase
    end

    assign be = be_base << off;

    // Replicate the low byte/half/word of the store data across every lane.
    always_comb begin
        wdata_rep = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            wdata_rep[8*i +: 8] = WriteData[8*(i & 32'(size_mask)) +: 8];
        end
    end

    // Response extraction from the latched lane
    logic [XLEN-1:0] rdata_sh;
    logic [XLEN-1:0] rdata_ext;

    assign rdata_sh = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  rdata_ext = XLEN'($signed(rdata_sh[7:0]));
            3'b001:  rdata_ext = XLEN'($signed(rdata_sh[15:0]));
            3'b010:  rdata_ext = XLEN'($signed(rdata_sh[31:0]));
            3'b100:  rdata_ext = XLEN'(rdata_sh[7:0]);
            3'b101:  rdata_ext = XLEN'(rdata_sh[15:0]);
            3'b110:  rdata_ext = XLEN'(rdata_sh[31:0]);
            default: rdata_ext = rdata_sh;
        endcase
    end

    // FSM next state and outputs
    logic issue;
    logic accept;
    logic tmo;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        issue       = 1'b0;
        accept      = 1'b0;
        tmo         = 1'b0;
        StallM      = 1'b0;
        valid_out   = 1'b0;
        RegWriteOut = 1'b0;
        misaligned  = 1'b0;
        bus_error   = 1'b0;
        load_data   = '0;
        mem_req     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (valid_in) begin
                    if (!memop) begin
                        valid_out   = 1'b1;
                        RegWriteOut = RegWrite;
                    end else if (fault) begin
                        valid_out  = 1'b1;
                        misaligned = 1'b1;
                    end else begin
                        StallM  = 1'b1;
                        issue   = 1'b1;
                        cnt_d   = '0;
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                mem_req = 1'b1;
                StallM  = 1'b1;
                cnt_d   = cnt_q + CntW'(1);
                // Timeout wins over a response arriving in the same cycle.
                if (cnt_q == CntW'(TIMEOUT)) begin
                    tmo     = 1'b1;
                    state_d = StDone;
                end else if (mem_gnt) begin
                    if (mem_rvalid) begin
                        accept  = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                StallM = 1'b1;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntW'(TIMEOUT)) begin
                    tmo     = 1'b1;
                    state_d = StDone;
                end else if (mem_rvalid) begin
                    accept  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                // EX/MEM still shows the completing instruction; it is ignored.
                valid_out   = 1'b1;
                load_data   = data_q;
                bus_error   = err_q;
                RegWriteOut = rw_q & ~err_q;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            off_q    <= '0;
            rw_q     <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (issue) begin
                addr_q   <= {ALUResult[ADDR_WIDTH-1:OffW], {OffW{1'b0}}};
                be_q     <= be;
                wdata_q  <= wdata_rep;
                we_q     <= MemWrite;
                funct3_q <= funct3;
                off_q    <= off;
                rw_q     <= RegWrite;
            end
            if (accept) begin
                data_q <= we_q ? '0 : rdata_ext;
                err_q  <= mem_err;
            end else if (tmo) begin
                data_q <= '0;
                err_q  <= 1'b1;
            end
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Bench for mem_stage_hs: a 32-bit instance (TIMEOUT 12) and a 64-bit
// instance (TIMEOUT 4) share stimulus; 'sel' picks which one is active.
module tb_mem_stage_hs;

    typedef struct {
        bit        sel;
        bit        rd;
        bit        wr;
        bit [2:0]  f3;
        bit [63:0] addr;
        bit [63:0] wd;
        bit        rw;
        int        g;      // REQ cycle index in which gnt is given
        int        r;      // cycles from gnt to rvalid
        bit [63:0] rdata;
        bit        err;
        bit        e_mis;
        bit [7:0]  e_be;
        bit [63:0] e_wdata;
        bit [63:0] e_ld;
        bit        e_berr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel, valid, rd, wr, rw, gnt, rvalid, err;
    logic [2:0]  f3;
    logic [63:0] alu, wd, rdata;

    logic        s32_stall, s32_vout, s32_rwo, s32_mis, s32_berr, s32_req, s32_we;
    logic [31:0] s32_ld, s32_addr, s32_wdata;
    logic [3:0]  s32_be;
    logic        s64_stall, s64_vout, s64_rwo, s64_mis, s64_berr, s64_req, s64_we;
    logic [63:0] s64_ld, s64_wdata;
    logic [31:0] s64_addr;
    logic [7:0]  s64_be;

    logic        o_stall, o_vout, o_rwo, o_mis, o_berr, o_req, o_we;
    logic [63:0] o_ld, o_wdata;
    logic [31:0] o_addr;
    logic [7:0]  o_be;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_stage_hs #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT(12)) u_dut32 (
        .clk(clk), .reset(reset), .valid_in(valid & ~sel), .MemRead(rd), .MemWrite(wr),
        .funct3(f3), .ALUResult(alu[31:0]), .WriteData(wd[31:0]), .RegWrite(rw),
        .StallM(s32_stall), .valid_out(s32_vout), .RegWriteOut(s32_rwo), .load_data(s32_ld),
        .misaligned(s32_mis), .bus_error(s32_berr), .mem_req(s32_req), .mem_we(s32_we),
        .mem_addr(s32_addr), .mem_be(s32_be), .mem_wdata(s32_wdata), .mem_gnt(gnt),
        .mem_rvalid(rvalid), .mem_rdata(rdata[31:0]), .mem_err(err)
    );

    mem_stage_hs #(.XLEN(64), .ADDR_WIDTH(32), .TIMEOUT(4)) u_dut64 (
        .clk(clk), .reset(reset), .valid_in(valid & sel), .MemRead(rd), .MemWrite(wr),
        .funct3(f3), .ALUResult(alu), .WriteData(wd), .RegWrite(rw),
        .StallM(s64_stall), .valid_out(s64_vout), .RegWriteOut(s64_rwo), .load_data(s64_ld),
        .misaligned(s64_mis), .bus_error(s64_berr), .mem_req(s64_req), .mem_we(s64_we),
        .mem_addr(s64_addr), .mem_be(s64_be), .mem_wdata(s64_wdata), .mem_gnt(gnt),
        .mem_rvalid(rvalid), .mem_rdata(rdata), .mem_err(err)
    );

    assign o_stall = sel ? s64_stall : s32_stall;
    assign o_vout  = sel ? s64_vout  : s32_vout;
    assign o_rwo   = sel ? s64_rwo   : s32_rwo;
    assign o_mis   = sel ? s64_mis   : s32_mis;
    assign o_berr  = sel ? s64_berr  : s32_berr;
    assign o_req   = sel ? s64_req   : s32_req;
    assign o_we    = sel ? s64_we    : s32_we;
    assign o_ld    = sel ? s64_ld    : {32'h0, s32_ld};
    assign o_wdata = sel ? s64_wdata : {32'h0, s32_wdata};
    assign o_addr  = sel ? s64_addr  : s32_addr;
    assign o_be    = sel ? s64_be    : {4'h0, s32_be};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit s, input bit r_, input bit w_, input bit [2:0] f,
                                input bit [63:0] a, input bit [63:0] d, input bit rwr,
                                input int g, input int r, input bit [63:0] rdt, input bit e,
                                input bit emis, input bit [7:0] ebe, input bit [63:0] ewd,
                                input bit [63:0] eld, input bit eberr);
        vec_t v;
        v.sel = s; v.rd = r_; v.wr = w_; v.f3 = f; v.addr = a; v.wd = d; v.rw = rwr;
        v.g = g; v.r = r; v.rdata = rdt; v.err = e;
        v.e_mis = emis; v.e_be = ebe; v.e_wdata = ewd; v.e_ld = eld; v.e_berr = eberr;
        return v;
    endfunction

    // Reference model: expected results from the access rules, by arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t      m = v;
        int        nb = v.sel ? 8 : 4;
        int        lim = v.sel ? 4 : 12;
        int        bytes = 1 << v.f3[1:0];
        int        lane = int'(v.addr % 64'(nb));
        int        width = 8 * bytes;
        bit        memop = v.rd | v.wr;
        bit        illegal;
        bit        tmo;
        bit [63:0] raw, wmask;
        illegal = (v.f3 == 3'd7) || (v.wr && v.f3[2]) ||
                  (!v.sel && (v.f3 == 3'd3 || v.f3 == 3'd6));
        m.e_mis = memop && (illegal || (v.addr % 64'(bytes) != 0));
        m.e_be = 8'((((64'd1 << bytes) - 64'd1) << lane) & ((64'd1 << nb) - 64'd1));
        m.e_wdata = '0;
        for (int i = 0; i < nb; i++) begin
            m.e_wdata |= ((v.wd >> (8 * (i % bytes))) & 64'hFF) << (8 * i);
        end
        wmask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        raw = (v.rdata >> (8 * lane)) & wmask;
        if (!v.f3[2] && width < 64 && raw[width-1]) raw |= ~wmask;
        if (!v.sel) raw &= 64'hFFFF_FFFF;
        tmo = (v.g + v.r) >= lim;
        m.e_berr = tmo || v.err;
        m.e_ld = (v.wr || tmo) ? 64'h0 : raw;
        return m;
    endfunction

    function automatic vec_t rand_vec(input bit s);
        vec_t v;
        int   op = $urandom_range(0, 2);
        v.sel = s;
        v.rd = (op == 1);
        v.wr = (op == 2);
        v.f3 = (op == 2) ? 3'($urandom_range(0, s ? 3 : 2)) : 3'($urandom_range(0, 6));
        v.addr = 64'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) v.addr &= ~64'h7;
        v.wd = {$urandom, $urandom};
        v.rdata = {$urandom, $urandom};
        v.rw = 1'($urandom_range(0, 1));
        v.g = $urandom_range(0, 3);
        v.r = $urandom_range(0, 4);
        v.err = ($urandom_range(0, 7) == 0);
        return v;
    endfunction

    // Drive one instruction through IDLE (and REQ/WAIT/DONE when it issues).
    task automatic apply(input vec_t v);
        int        nb = v.sel ? 8 : 4;
        int        lim = v.sel ? 4 : 12;
        int        k = v.g + v.r;
        bit        memop = v.rd | v.wr;
        bit        tmo = k >= lim;
        int        last = tmo ? lim : k;
        bit [63:0] ea = v.addr & ~64'(nb - 1);
        @(posedge clk); #1;
        sel = v.sel; valid = 1'b1; rd = v.rd; wr = v.wr; f3 = v.f3; alu = v.addr;
        wd = v.wd; rw = v.rw; gnt = 1'b0; rvalid = 1'b0; rdata = v.rdata; err = v.err;
        @(negedge clk);
        if (!memop || v.e_mis) begin
            chk("imm_valid_out", o_vout, 1'b1);
            chk("imm_misaligned", o_mis, v.e_mis);
            chk("imm_regwrite", o_rwo, v.rw & ~v.e_mis);
            chk("imm_stall", o_stall, 1'b0);
            chk("imm_req", o_req, 1'b0);
            @(posedge clk); #1;
            valid = 1'b0;
            @(negedge clk);
            chk("imm_next_req", o_req, 1'b0);
        end else begin
            chk("issue_stall", o_stall, 1'b1);
            chk("issue_valid_out", o_vout, 1'b0);
            for (int j = 0; j <= last; j++) begin
                @(posedge clk); #1;
                gnt = (j == v.g);
                rvalid = (j == k);
                @(negedge clk);
                chk("busy_stall", o_stall, 1'b1);
                chk("busy_valid_out", o_vout, 1'b0);
                if (j <= v.g) begin
                    chk("req_high", o_req, 1'b1);
                    chk("req_addr", 64'(o_addr), ea & 64'hFFFF_FFFF);
                    chk("req_be", 64'(o_be), 64'(v.e_be));
                    chk("req_wdata", o_wdata, v.e_wdata);
                    chk("req_we", o_we, v.wr);
                end else begin
                    chk("wait_req_low", o_req, 1'b0);
                end
            end
            // DONE: drive a stray response, which must be ignored.
            @(posedge clk); #1;
            gnt = 1'b1; rvalid = 1'b1; rdata = ~v.rdata; err = ~v.err;
            @(negedge clk);
            chk("done_valid_out", o_vout, 1'b1);
            chk("done_stall", o_stall, 1'b0);
            chk("done_misaligned", o_mis, 1'b0);
            chk("done_bus_error", o_berr, v.e_berr);
            chk("done_regwrite", o_rwo, v.rw & ~v.e_berr);
            if (!(v.err && !tmo)) chk("done_load_data", o_ld, v.e_ld);
            @(posedge clk); #1;
            valid = 1'b0; gnt = 1'b0; rvalid = 1'b0;
            @(negedge clk);
            chk("after_valid_out", o_vout, 1'b0);
            chk("after_stall", o_stall, 1'b0);
            chk("after_req", o_req, 1'b0);
        end
    endtask

    // Reset while a lw is in REQ (in_wait=0) or WAIT (in_wait=1), then a stale rvalid.
    task automatic reset_mid(input bit in_wait);
        @(posedge clk); #1;
        sel = 1'b0; valid = 1'b1; rd = 1'b1; wr = 1'b0; f3 = 3'b010; alu = 64'h300;
        rw = 1'b1; gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rdata = 64'h0;
        @(negedge clk);
        chk("rst_issue_stall", o_stall, 1'b1);
        @(posedge clk); #1;
        gnt = in_wait;
        @(negedge clk);
        chk("rst_req_high", o_req, 1'b1);
        if (in_wait) begin
            @(posedge clk); #1;
            gnt = 1'b0;
            @(negedge clk);
            chk("rst_wait_stall", o_stall, 1'b1);
        end
        #1; reset = 1'b1; valid = 1'b0;
        #1;
        chk("rst_req_drop", o_req, 1'b0);
        chk("rst_stall_drop", o_stall, 1'b0);
        chk("rst_valid_out", o_vout, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            rvalid = (j == 0); gnt = (j == 0); rdata = 64'hBAD0_BAD0;
            @(negedge clk);
            chk("stale_valid_out", o_vout, 1'b0);
            chk("stale_stall", o_stall, 1'b0);
            chk("stale_req", o_req, 1'b0);
        end
        rvalid = 1'b0; gnt = 1'b0;
    endtask

    initial begin
        vec_t tbl[$];
        reset = 1'b1; sel = 1'b0; valid = 1'b0; rd = 1'b0; wr = 1'b0; rw = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; err = 1'b0; f3 = 3'b000; alu = '0; wd = '0; rdata = '0;

        // sel, rd, wr, f3, addr, wd, rw, g, r, rdata, err | mis, be, wdata, ld, berr
        tbl.push_back(mk(0,1,0,3'b010,64'h104,64'h0,1,0,0,64'hDEADBEEF,0, 0,8'h0F,64'h0,64'hDEADBEEF,0));
        tbl.push_back(mk(0,1,0,3'b000,64'h103,64'h0,1,0,0,64'h80FFFF7F,0, 0,8'h08,64'h0,64'hFFFFFF80,0));
        tbl.push_back(mk(0,1,0,3'b100,64'h103,64'h0,1,0,0,64'h80FFFF7F,0, 0,8'h08,64'h0,64'h80,0));
        tbl.push_back(mk(0,0,1,3'b001,64'h102,64'h1234ABCD,0,1,0,64'h0,0, 0,8'h0C,64'hABCDABCD,64'h0,0));
        tbl.push_back(mk(0,0,1,3'b010,64'h101,64'h55,1,0,0,64'h0,0, 1,8'h0,64'h0,64'h0,0));
        tbl.push_back(mk(0,1,0,3'b011,64'h100,64'h0,1,0,0,64'h0,0, 1,8'h0,64'h0,64'h0,0));
        tbl.push_back(mk(0,1,0,3'b110,64'h100,64'h0,1,0,0,64'h0,0, 1,8'h0,64'h0,64'h0,0));
        tbl.push_back(mk(0,1,0,3'b001,64'h101,64'h0,1,0,0,64'h0,0, 1,8'h0,64'h0,64'h0,0));
        tbl.push_back(mk(0,0,0,3'b010,64'h101,64'h0,1,0,0,64'h0,0, 0,8'h0,64'h0,64'h0,0));
        tbl.push_back(mk(0,1,0,3'b010,64'h200,64'h0,1,3,5,64'h11223344,0, 0,8'h0F,64'h0,64'h11223344,0));
        tbl.push_back(mk(0,0,1,3'b010,64'h204,64'hCAFEF00D,0,2,2,64'h77,0, 0,8'h0F,64'hCAFEF00D,64'h0,0));
        tbl.push_back(mk(0,1,0,3'b101,64'h202,64'h0,1,0,1,64'h80017FFF,0, 0,8'h0C,64'h0,64'h8001,0));
        tbl.push_back(mk(0,1,0,3'b001,64'h202,64'h0,1,1,0,64'h80017FFF,0, 0,8'h0C,64'h0,64'hFFFF8001,0));
        tbl.push_back(mk(1,1,0,3'b010,64'h40,64'h0,1,0,9,64'h1234,0, 0,8'h0F,64'h0,64'h0,1));
        tbl.push_back(mk(1,1,0,3'b010,64'h40,64'h0,1,1,1,64'h1234,1, 0,8'h0F,64'h0,64'h0,1));
        tbl.push_back(mk(1,1,0,3'b010,64'h40,64'h0,1,0,4,64'h5555,0, 0,8'h0F,64'h0,64'h0,1));
        tbl.push_back(mk(1,1,0,3'b010,64'h44,64'h0,1,1,2,64'h89ABCDEF_00000000,0, 0,8'hF0,64'h0,64'hFFFFFFFF_89ABCDEF,0));
        tbl.push_back(mk(1,1,0,3'b011,64'h08,64'h0,1,0,0,64'h01234567_89ABCDEF,0, 0,8'hFF,64'h0,64'h01234567_89ABCDEF,0));
        tbl.push_back(mk(1,1,0,3'b110,64'h0C,64'h0,1,0,0,64'hF0000000_12345678,0, 0,8'hF0,64'h0,64'h00000000_F0000000,0));
        tbl.push_back(mk(1,0,1,3'b011,64'h10,64'h11223344_55667788,0,0,1,64'h0,0, 0,8'hFF,64'h11223344_55667788,64'h0,0));
        tbl.push_back(mk(1,0,1,3'b010,64'h04,64'h99999999_AABBCCDD,0,1,1,64'h0,0, 0,8'hF0,64'hAABBCCDD_AABBCCDD,64'h0,0));
        tbl.push_back(mk(1,0,1,3'b000,64'h05,64'h127E,0,0,0,64'h0,0, 0,8'h20,64'h7E7E7E7E_7E7E7E7E,64'h0,0));
        tbl.push_back(mk(1,1,0,3'b011,64'h0C,64'h0,1,0,0,64'h0,0, 1,8'h0,64'h0,64'h0,0));
        tbl.push_back(mk(1,0,1,3'b001,64'h06,64'hBEEF,0,0,0,64'h0,0, 0,8'hC0,64'hBEEFBEEF_BEEFBEEF,64'h0,0));
        tbl.push_back(mk(1,1,0,3'b000,64'h07,64'h0,1,0,0,64'h7F000000_00000080,0, 0,8'h80,64'h0,64'h7F,0));
        tbl.push_back(mk(1,0,0,3'b000,64'h00,64'h0,0,0,0,64'h0,0, 0,8'h0,64'h0,64'h0,0));

        #12;
        chk("reset_stall32", s32_stall, 1'b0);
        chk("reset_vout32", s32_vout, 1'b0);
        chk("reset_req32", s32_req, 1'b0);
        chk("reset_stall64", s64_stall, 1'b0);
        chk("reset_vout64", s64_vout, 1'b0);
        chk("reset_req64", s64_req, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (tbl[i]) apply(tbl[i]);

        reset_mid(1'b1);
        apply(tbl[0]);
        reset_mid(1'b0);
        apply(tbl[0]);

        for (int i = 0; i < 80; i++) begin
            vec_t v;
            v = model(rand_vec(1'(i % 2)));
            apply(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
